// File: rtl/bram_bank_loader.sv
// bram_bank_loader: accepts an AXI-Stream word sequence and spreads it across
// BANKS block RAMs in an interleaved layout (word n -> bank n%BANKS, address
// n/BANKS). Write-port outputs are registered one cycle behind the accepted beat.
// Optional feature: define BRAM_BANK_LOADER_TLAST_CHECK_EN to enable the sticky
// tlast framing check; without it s_axis_tlast is ignored and error stays 0.
//
// state | meaning
// IDLE  | waiting for start; stream not accepted
// LOAD  | accepting beats and writing banks
// DONE  | load finished; done pulses on the following cycle

module bram_bank_loader #(
  parameter int BANKS = 4,
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int ADDR  = $clog2(DEPTH),
  parameter int WE    = WIDTH / 8,
  parameter int CNT_W = $clog2(BANKS * DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       count,
  input  logic [WIDTH-1:0]       s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic [BANKS-1:0]       ena,
  output logic [BANKS*WE-1:0]    wea,
  output logic [BANKS*ADDR-1:0]  addra,
  output logic [BANKS*WIDTH-1:0] dina,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(BANKS * DEPTH);
  localparam logic [BW-1:0]    LAST_BANK = BW'(BANKS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] total;
  logic [CNT_W-1:0] beat_cnt;
  logic [BW-1:0]    bank_idx;
  logic [ADDR-1:0]  addr_idx;
  logic             beat;
  logic             last_beat;

  assign s_axis_tready = (state == LOAD);
  assign busy          = (state == LOAD);
  assign beat          = s_axis_tready && s_axis_tvalid;
  assign last_beat     = beat && (beat_cnt == total - 1'b1);

  // Sequencer: start latches the clamped length, beats walk bank then address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      total    <= '0;
      beat_cnt <= '0;
      bank_idx <= '0;
      addr_idx <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            total    <= (count > MAX_WORDS) ? MAX_WORDS : count;
            beat_cnt <= '0;
            bank_idx <= '0;
            addr_idx <= '0;
            state    <= (count == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
            // Explicit wrap so non-power-of-two bank counts stay in range.
            if (bank_idx == LAST_BANK) begin
              bank_idx <= '0;
              addr_idx <= addr_idx + 1'b1;
            end else begin
              bank_idx <= bank_idx + 1'b1;
            end
            if (last_beat) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Registered write port: enables are single-cycle, address/data slices hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      ena   <= '0;
      wea   <= '0;
      addra <= '0;
      dina  <= '0;
    end else begin
      ena <= '0;
      wea <= '0;
      if (beat) begin
        for (int i = 0; i < BANKS; i++) begin
          if (bank_idx == BW'(i)) begin
            ena[i]                  <= 1'b1;
            wea[i*WE +: WE]         <= '1;
            addra[i*ADDR +: ADDR]   <= addr_idx;
            dina[i*WIDTH +: WIDTH]  <= s_axis_tdata;
          end
        end
      end
    end
  end

`ifdef BRAM_BANK_LOADER_TLAST_CHECK_EN
  // Sticky framing flag: tlast must coincide exactly with the final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      error <= 1'b0;
    end else if (state == IDLE && start) begin
      error <= 1'b0;
    end else if (beat && (last_beat != s_axis_tlast)) begin
      error <= 1'b1;
    end
  end
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_bram_bank_loader.sv
// Testbench for bram_bank_loader (BANKS=4, WIDTH=16, DEPTH=256).
// A word-level model predicts every output each cycle; a capture memory
// records DUT writes for the directed literal checks.

module tb_bram_bank_loader;

  localparam int B   = 4;
  localparam int W   = 16;
  localparam int D   = 256;
  localparam int AW  = 8;
  localparam int WEB = 2;
  localparam int CW  = 11;
`ifdef BRAM_BANK_LOADER_TLAST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [CW-1:0]   count = '0;
  logic [W-1:0]    tdata = '0;
  logic            tvalid = 1'b0;
  logic            tlast = 1'b0;
  logic            tready;
  logic [B-1:0]    ena;
  logic [B*WEB-1:0] wea;
  logic [B*AW-1:0] addra;
  logic [B*W-1:0]  dina;
  logic            busy, done, error;

  bram_bank_loader dut (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .s_axis_tlast(tlast), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ecount = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ecount);
    end
  endtask

  // ---------------- word-level model ----------------
  bit              m_ok = 0;
  bit              m_loading = 0;
  bit              m_stage = 0;   // load finished, done follows next cycle
  bit              m_done = 0;
  bit              m_err = 0;
  int              m_total = 0;
  int              m_n = 0;
  logic [B-1:0]    e_ena = '0;
  logic [B*WEB-1:0] e_wea = '0;
  logic [B*AW-1:0] e_addra = '0;
  logic [B*W-1:0]  e_dina = '0;

  always @(posedge clk) begin : model
    bit idle, was_stage;
    int b, a;
    ecount++;
    if (rst) begin
      m_ok = 1; m_loading = 0; m_stage = 0; m_done = 0; m_err = 0;
      m_total = 0; m_n = 0;
      e_ena = '0; e_wea = '0; e_addra = '0; e_dina = '0;
    end else begin
      idle = !m_loading && !m_stage;
      was_stage = m_stage;
      m_stage = 0;
      e_ena = '0;
      e_wea = '0;
      if (m_loading && tvalid) begin
        b = m_n % B;
        a = m_n / B;
        e_ena[b] = 1'b1;
        e_wea[b*WEB +: WEB] = '1;
        e_addra[b*AW +: AW] = AW'(a);
        e_dina[b*W +: W] = tdata;
        if (CHK && ((m_n == m_total - 1) != tlast)) m_err = 1;
        m_n++;
        if (m_n == m_total) begin
          m_loading = 0;
          m_stage = 1;
        end
      end
      if (idle && start) begin
        m_total = (int'(count) > B * D) ? B * D : int'(count);
        m_n = 0;
        m_err = 0;
        if (m_total == 0) m_stage = 1;
        else m_loading = 1;
      end
      m_done = was_stage;
    end
  end

  // ---------------- per-cycle compare + capture ----------------
  logic [W-1:0] cap_mem [B*D];
  int cap_writes = 0;
  int last_bank = -1, last_addr = -1, last_wr_cyc = -1, done_cyc = -1;

  always @(negedge clk) begin
    if (m_ok) begin
      check("tready", tready, m_loading);
      check("busy", busy, m_loading);
      check("done", done, m_done);
      check("error", error, m_err);
      check("ena", ena, e_ena);
      check("wea", wea, e_wea);
      check("addra", addra, e_addra);
      check("dina", dina, e_dina);
      for (int b = 0; b < B; b++) begin
        if (ena[b]) begin
          cap_writes++;
          cap_mem[b*D + int'(addra[b*AW +: AW])] = dina[b*W +: W];
          last_bank = b;
          last_addr = int'(addra[b*AW +: AW]);
          last_wr_cyc = ecount;
        end
      end
      if (done) done_cyc = ecount;
    end
  end

  // ---------------- stimulus ----------------
  int start_cyc = 0;

  task automatic clr();
    cap_writes = 0;
    last_bank = -1; last_addr = -1; last_wr_cyc = -1; done_cyc = -1;
    for (int i = 0; i < B*D; i++) cap_mem[i] = '0;
  endtask

  task automatic start_load(input int n);
    @(negedge clk);
    start = 1'b1;
    count = CW'(n);
    start_cyc = ecount;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int n, input int base, input bit toggle, input int tlast_at);
    int k = 0;
    int cyc = 0;
    bit ph = 1'b1;
    while (k < n && cyc < 5000) begin
      tvalid = toggle ? ph : 1'b1;
      tdata  = W'(base + k);
      tlast  = (k == tlast_at);
      ph = !ph;
      if (tvalid && tready) k++;
      @(negedge clk);
      cyc++;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    check("beats_accepted", k, n);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_ena", ena, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // 8 words back-to-back
    clr();
    start_load(8);
    send(8, 'h0100, 1'b0, -1);
    settle();
    check("t1_writes", cap_writes, 8);
    check("t1_b0a0", cap_mem[0*D+0], 'h0100);
    check("t1_b3a0", cap_mem[3*D+0], 'h0103);
    check("t1_b0a1", cap_mem[0*D+1], 'h0104);
    check("t1_b3a1", cap_mem[3*D+1], 'h0107);
    check("t1_done_lag", done_cyc - last_wr_cyc, 1);
    check("t1_busy_after", busy, 0);

    // 5 words with tvalid toggling
    clr();
    start_load(5);
    send(5, 'h0200, 1'b1, -1);
    settle();
    check("t2_writes", cap_writes, 5);
    check("t2_b0a1", cap_mem[0*D+1], 'h0204);
    check("t2_last_bank", last_bank, 0);

    // count 0, plus a start during DONE that must be ignored
    clr();
    @(negedge clk);
    start = 1'b1; count = '0; start_cyc = ecount;
    @(negedge clk);
    count = CW'(3);
    @(negedge clk);
    start = 1'b0;
    settle();
    check("t3_writes", cap_writes, 0);
    check("t3_done_lag", done_cyc - start_cyc, 2);
    check("t3_busy", busy, 0);

    // count beyond capacity is clamped to 1024
    clr();
    start_load(2000);
    send(1024, 'h1000, 1'b0, -1);
    settle();
    check("t4_writes", cap_writes, 1024);
    check("t4_last_bank", last_bank, 3);
    check("t4_last_addr", last_addr, 255);
    check("t4_last_data", cap_mem[3*D+255], 'h13FF);
    check("t4_done_lag", done_cyc - last_wr_cyc, 1);

    // reset mid-load, then a fresh load starts from bank 0 addr 0
    clr();
    start_load(8);
    send(3, 'h0300, 1'b0, -1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("t5_ena", ena, 0);
    check("t5_wea", wea, 0);
    check("t5_addra", addra, 0);
    check("t5_dina", dina, 0);
    check("t5_busy", busy, 0);
    check("t5_tready", tready, 0);
    rst = 1'b0;
    clr();
    start_load(4);
    send(4, 'h0400, 1'b0, -1);
    settle();
    check("t5_writes", cap_writes, 4);
    check("t5_b0a0", cap_mem[0*D+0], 'h0400);
    check("t5_b3a0", cap_mem[3*D+0], 'h0403);

    // tlast on the wrong beat
    clr();
    start_load(4);
    send(4, 'h0500, 1'b0, 1);
    settle();
    check("t6_writes", cap_writes, 4);
    check("t6_error", error, CHK);
    start_load(1);
    send(1, 'h0600, 1'b0, 0);
    settle();
    check("t6_error_cleared", error, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/bram_bank_loader.md
BRAM_BANK_LOADER -- requirements
Module: bram_bank_loader

Interface
REQ-001 SHALL have parameter BANKS, default 4, number of BRAM banks fed.
REQ-002 SHALL have parameter WIDTH, default 16, bits per word.
REQ-003 SHALL have parameter DEPTH, default 256, words per bank.
REQ-004 SHALL have parameter ADDR, default $clog2(DEPTH), bank address width.
REQ-005 SHALL have parameter WE, default WIDTH/8, byte-enable bits per bank.
REQ-006 SHALL have parameter CNT_W, default $clog2(BANKS*DEPTH+1), word-count width.
REQ-007 clk  input  1  single clock; one clock; reset is synchronous and active-high.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 start  input  1  one-cycle pulse; begins a load.
REQ-010 count  input  CNT_W  total words to load, sampled on start.
REQ-011 s_axis_tdata  input  WIDTH  stream data word.
REQ-012 s_axis_tvalid  input  1  stream word valid.
REQ-013 s_axis_tready  output  1  loader accepts word.
REQ-014 s_axis_tlast  input  1  stream final-word marker.
REQ-015 ena  output  BANKS  per-bank port-A enable.
REQ-016 wea  output  BANKS*WE  per-bank byte write enables.
REQ-017 addra  output  BANKS*ADDR  per-bank port-A address, bank i in slice i.
REQ-018 dina  output  BANKS*WIDTH  per-bank write data, bank i in slice i.
REQ-019 busy  output  1  high in LOAD state.
REQ-020 done  output  1  one-cycle pulse at end of load.
REQ-021 error  output  1  sticky framing error flag.

Function
REQ-022 FSM states SHALL be IDLE, LOAD, DONE.
REQ-023 IDLE: start=1 latches min(count, BANKS*DEPTH), clears bank_idx, addr_idx, beat counter and error; goes to LOAD, or to DONE if latched count is 0.
REQ-024 LOAD: s_axis_tready=1; a beat is tvalid&&tready.
REQ-025 Each beat SHALL write tdata to bank bank_idx at address addr_idx.
REQ-026 bank_idx SHALL increment per beat and wrap BANKS-1 -> 0; addr_idx SHALL increment only on that wrap (interleaved layout: word n -> bank n%BANKS, addr n/BANKS).
REQ-027 Write outputs SHALL be registered: the beat in cycle t drives ena[b]=1, wea slice b all ones, addra/dina slice b in cycle t+1; all other banks ena=0, wea=0.
REQ-028 Cycles without a beat SHALL drive ena=0 and wea=0 on all banks in the following cycle.
REQ-029 Beat number count-1 SHALL move FSM to DONE in the next cycle.
REQ-030 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-031 s_axis_tready SHALL be 0 in IDLE and DONE.
REQ-032 start in LOAD or DONE SHALL be ignored.
REQ-033 busy SHALL be 1 exactly while in LOAD.
REQ-034 Unused addra/dina slices SHALL hold their last values.

Reset
REQ-035 rst=1 at any clock edge, including mid-load, SHALL force IDLE and clear counters.
REQ-036 Reset values: s_axis_tready=0, ena=0, wea=0, addra=0, dina=0, busy=0, done=0, error=0.
REQ-037 A partially loaded transfer aborted by reset SHALL not be resumed.

Configuration
REQ-038 Macro BRAM_BANK_LOADER_TLAST_CHECK_EN defined: error SHALL set when tlast=1 on a beat other than count-1 or tlast=0 on beat count-1; load still completes all count beats; error held until next accepted start or reset.
REQ-039 Macro undefined: s_axis_tlast SHALL be ignored and error tied to 0.

Verification (BANKS=4, WIDTH=16, DEPTH=256)
REQ-040 start, count=8, data 0x0100..0x0107 back-to-back -> banks 0..3 addr 0 get 0x0100..0x0103, addr 1 get 0x0104..0x0107; done one cycle after eighth write; busy low afterwards.
REQ-041 count=5 with tvalid toggling every other cycle -> exactly 5 writes, ena one-hot per write, no writes in idle cycles, word 4 to bank 0 addr 1.
REQ-042 count=0 -> no tready, no writes, done pulses two cycles after start.
REQ-043 count=2000 (>1024) -> exactly 1024 writes, last to bank 3 addr 255, then done.
REQ-044 rst asserted after 3 beats of count=8 -> next cycle all outputs 0, state IDLE; new start count=4 writes from bank 0 addr 0.
REQ-045 With macro, count=4, tlast on beat 1 -> error=1 after beat 1, 4 writes completed, error cleared by next start; without macro error stays 0.
